// File: rtl/sram_wb_primary_controller_pkg.sv
// sram_wb_primary_controller_pkg: state encoding and address-slice constants shared by the controller.
// Revision: 1.0
`default_nettype none

package sram_wb_primary_controller_pkg;

  localparam logic [1:0] STATE_IDLE      = 2'd0;
  localparam logic [1:0] STATE_READ_WAIT = 2'd1;
  localparam logic [1:0] STATE_ACK       = 2'd2;

  // Byte-offset bits dropped from the Wishbone byte address (4 bytes per word).
  localparam int BYTE_OFFSET_W = 2;

endpackage

`default_nettype wire

// File: rtl/sram_wb_primary_controller_if.sv
// sram_wb_primary_controller_if: Wishbone B4 classic bus bundle with master/slave views.
// Revision: 1.0
`default_nettype none

interface sram_wb_primary_controller_if #(
  parameter int BYTE_COUNT      = 4,
  parameter int WB_ADDRESS_SIZE = 24
);

  localparam int WORD_SIZE = 8 * BYTE_COUNT;

  logic                       wb_cyc_i;
  logic                       wb_stb_i;
  logic                       wb_we_i;
  logic [BYTE_COUNT-1:0]      wb_sel_i;
  logic [WB_ADDRESS_SIZE-1:0] wb_adr_i;
  logic [WORD_SIZE-1:0]       wb_data_i;
  logic                       wb_ack_o;
  logic [WORD_SIZE-1:0]       wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_data_o
  );

endinterface

`default_nettype wire

// File: rtl/sram_wb_primary_controller.sv
// sram_wb_primary_controller: Wishbone classic slave driving the primary RW port of an SRAM bank.
// Revision: 1.0
`default_nettype none

module sram_wb_primary_controller
  import sram_wb_primary_controller_pkg::*;
#(
  parameter int BYTE_COUNT      = 4,
  parameter int ADDRESS_SIZE    = 9,
  parameter int WB_ADDRESS_SIZE = 24,
  localparam int WORD_SIZE      = 8 * BYTE_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_wb_primary_controller_if.slave wb,
  output logic                    primarySelect,
  output logic                    primaryWriteEnable,
  output logic [BYTE_COUNT-1:0]   primaryWriteMask,
  output logic [ADDRESS_SIZE-1:0] primaryAddress,
  output logic [WORD_SIZE-1:0]    primaryDataWrite,
  input  logic [WORD_SIZE-1:0]    primaryDataRead
);

  logic [1:0]           state;
  logic [WORD_SIZE-1:0] read_data;
  logic                 request;
  logic                 accept;
  logic                 unused_adr;

  assign request    = wb.wb_cyc_i & wb.wb_stb_i;
  // The ACK cycle is deliberately not an accept point, so a held strobe is never taken twice.
  assign accept     = (state == STATE_IDLE) && request && !rst;
  assign unused_adr = ^wb.wb_adr_i;

  always_comb begin
    primarySelect      = 1'b0;
    primaryWriteEnable = 1'b0;
    primaryWriteMask   = '0;
    primaryAddress     = '0;
    primaryDataWrite   = '0;
    if (accept) begin
      primarySelect      = 1'b1;
      primaryWriteEnable = wb.wb_we_i;
      primaryWriteMask   = wb.wb_we_i ? wb.wb_sel_i : '0;
      primaryAddress     = wb.wb_adr_i[BYTE_OFFSET_W +: ADDRESS_SIZE];
      primaryDataWrite   = wb.wb_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STATE_IDLE;
      read_data <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (request) state <= wb.wb_we_i ? STATE_ACK : STATE_READ_WAIT;
        end
        STATE_READ_WAIT: begin
          if (wb.wb_cyc_i) begin
            read_data <= primaryDataRead;
            state     <= STATE_ACK;
          end else begin
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o  = (state == STATE_ACK);
  assign wb.wb_data_o = read_data;

endmodule

`default_nettype wire
